unified_mem_arbiter: RTL and testbench

Shares one single-ported unified memory between the core's instruction-fetch port and data (load/store) port, replacing the separate mem_I / mem_D arrangement. It runs a grant state machine with a req/ack handshake on each side. Data requests get priority, with a bounded streak so that fetch cannot starve. A watchdog terminates transactions the memory never acknowledges.

---
 rtl/arb_pkg.sv | 34 +++
 rtl/mem_watchdog.sv | 35 +++
 rtl/unified_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_unified_mem_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the unified memory arbiter.
package arb_pkg;

  // Grant state machine states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  // Which port the IDLE arbitration decided to serve.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_I    = 2'd1,
    SEL_D    = 2'd2
  } grant_sel_t;

  // Read data returned to a requester whose transaction was aborted.
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  // Data wins ties unless it has used up its streak while fetch waited.
  function automatic grant_sel_t pick_grant(input logic i_req,
                                            input logic d_req,
                                            input logic streak_full);
    if (d_req && !(i_req && streak_full))
      return SEL_D;
    else if (i_req)
      return SEL_I;
    else
      return SEL_NONE;
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts cycles spent waiting in a grant state and flags an abort
// one cycle after the last permitted cycle passes without mem_ack.
module mem_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic active,
  input  logic ack,
  output logic expire
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] wd_cnt;

  // Clear on grant entry, count while granted, register the expiry compare.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      expire <= 1'b0;
    end else if (start) begin
      wd_cnt <= '0;
      expire <= 1'b0;
    end else if (active) begin
      wd_cnt <= wd_cnt + 1'b1;
      expire <= (wd_cnt == LAST) && !ack;
    end else begin
      expire <= 1'b0;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported memory between fetch (I) and data (D)
// ports. D has priority with a bounded streak; a watchdog aborts
// transactions that never see mem_ack. All outputs come from flops.
module unified_mem_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_req,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err_timeout
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  arb_state_t      state_reg, state_next;
  grant_sel_t      grant;
  logic [SW-1:0]   d_streak;
  logic            wd_start, wd_active, wd_expire;

  assign wd_start  = (state_reg == IDLE) && (grant != SEL_NONE);
  assign wd_active = (state_reg == GRANT_I) || (state_reg == GRANT_D);

  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (wd_start),
    .active (wd_active),
    .ack    (mem_ack),
    .expire (wd_expire)
  );

  // Next-state: arbitrate in IDLE, leave grant on ack or expiry.
  always_comb begin
    state_next = state_reg;
    grant      = SEL_NONE;
    case (state_reg)
      IDLE: begin
        grant = pick_grant(i_req, d_req, d_streak == STREAK_MAX);
        if (grant == SEL_I)      state_next = GRANT_I;
        else if (grant == SEL_D) state_next = GRANT_D;
      end
      GRANT_I, GRANT_D: begin
        if (mem_ack || wd_expire) state_next = RESP;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, registered memory-side copy, response data and ack pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      d_streak    <= '0;
      mem_req     <= 1'b0;
      mem_wen     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      i_ack       <= 1'b0;
      d_ack       <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_reg <= state_next;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant == SEL_I) begin
            mem_req   <= 1'b1;
            mem_wen   <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            d_streak  <= '0;
          end else if (grant == SEL_D) begin
            mem_req   <= 1'b1;
            mem_wen   <= d_wen;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (!i_req)
              d_streak <= '0;
            else if (d_streak != STREAK_MAX)
              d_streak <= d_streak + 1'b1;
          end
        end
        GRANT_I, GRANT_D: begin
          if (mem_ack || wd_expire) begin
            mem_req   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if (!mem_ack) err_timeout <= 1'b1;
            if (state_reg == GRANT_I) begin
              i_ack   <= 1'b1;
              i_rdata <= mem_ack ? mem_rdata : ERR_RDATA;
            end else begin
              d_ack   <= 1'b1;
              d_rdata <= !mem_ack ? ERR_RDATA : (mem_wen ? '0 : mem_rdata);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: table of single transactions plus hand sequences for
// streak fairness, stray acks and reset during a grant.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_wen, mem_ack;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_ack, d_ack, mem_req, mem_wen, err_timeout;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  unified_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .err_timeout(err_timeout)
  );

  typedef struct {
    logic        is_d;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          lat;        // grant cycle (1-based) carrying mem_ack; 0 = never
    logic [31:0] exp_rdata;
    int          exp_lat;    // cycles from mem_req rising to ack visible
  } txn_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input txn_t t);
    int   n;
    logic done;
    if (t.is_d) begin
      d_req = 1'b1; d_wen = t.wen; d_addr = t.addr; d_wdata = t.wdata;
    end else begin
      i_req = 1'b1; i_addr = t.addr;
    end
    step();
    check("mem_req", {31'd0, mem_req}, 32'd1);
    check("mem_addr", mem_addr, t.addr);
    check("mem_wen", {31'd0, mem_wen}, {31'd0, t.is_d & t.wen});
    check("mem_wdata", mem_wdata, t.is_d ? t.wdata : 32'd0);
    n = 0; done = 1'b0;
    while (!done && n < 100) begin
      if (t.lat != 0 && n == t.lat - 1) begin
        mem_ack = 1'b1; mem_rdata = t.mrdata;
      end
      step();
      mem_ack = 1'b0; mem_rdata = 32'hBAD0_BAD0;
      n++;
      if (i_ack || d_ack) done = 1'b1;
    end
    if (t.lat == 0) exp_err = 1'b1;
    check("ack_latency", n, t.exp_lat);
    check("x_ack", {31'd0, t.is_d ? d_ack : i_ack}, 32'd1);
    check("other_ack", {31'd0, t.is_d ? i_ack : d_ack}, 32'd0);
    check("x_rdata", t.is_d ? d_rdata : i_rdata, t.exp_rdata);
    check("err_timeout", {31'd0, err_timeout}, {31'd0, exp_err});
    i_req = 1'b0; d_req = 1'b0;
    step();
    check("ack_pulse_end", {30'd0, i_ack, d_ack}, 32'd0);
    check("mem_req_idle", {31'd0, mem_req}, 32'd0);
    $display("txn %s addr=%h lat=%0d rdata_i=%h rdata_d=%h err=%b",
             t.is_d ? (t.wen ? "STORE" : "LOAD") : "FETCH", t.addr, n, i_rdata, d_rdata, err_timeout);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {26'd0, mem_req, mem_wen, i_ack, d_ack, err_timeout, 1'b0}, 32'd0);
    check({tag, "_data"}, mem_addr | mem_wdata | i_rdata | d_rdata, 32'd0);
  endtask

  txn_t tbl [7];
  txn_t ft;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'h100, 32'h0,         32'h1234_5678, 1, 32'h1234_5678, 1};
    tbl[1] = '{1'b1, 1'b1, 32'h20,  32'hCAFE_F00D, 32'h5555_AAAA, 1, 32'h0,         1};
    tbl[2] = '{1'b0, 1'b0, 32'h40,  32'h0,         32'h0BAD_F00D, 1, 32'h0BAD_F00D, 1};
    tbl[3] = '{1'b1, 1'b0, 32'h44,  32'h0,         32'h8765_4321, 3, 32'h8765_4321, 3};
    tbl[4] = '{1'b0, 1'b0, 32'h300, 32'h0,         32'h1111_1111, 0, 32'hDEAD_BEEF, 65};
    tbl[5] = '{1'b0, 1'b0, 32'h48,  32'h0,         32'hA5A5_5A5A, 2, 32'hA5A5_5A5A, 2};
    tbl[6] = '{1'b1, 1'b1, 32'h4C,  32'h0102_0304, 32'hFFFF_FFFF, 2, 32'h0,         2};

    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wen = 1'b0; mem_ack = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = 32'hBAD0_BAD0;
    step(); step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Stray mem_ack while idle must not produce any response.
    for (int c = 0; c < 3; c++) begin
      mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
      step();
      check("stray_ack", {29'd0, i_ack, d_ack, mem_req}, 32'd0);
    end
    mem_ack = 1'b0;

    for (int k = 0; k < 7; k++) run_txn(tbl[k]);

    // Both ports held: four D grants, then I, repeating.
    begin
      int k = 0;
      int cyc = 0;
      i_req = 1'b1; d_req = 1'b1; d_wen = 1'b0; i_addr = 32'h1000; d_addr = 32'h2000;
      while (k < 10 && cyc < 80) begin
        step();
        cyc++;
        mem_ack = 1'b0;
        if (mem_req) begin
          logic exp_d;
          exp_d = ((k % 5) != 4);
          check("grant_order", mem_addr, exp_d ? 32'h2000 : 32'h1000);
          $display("grant %0d -> %s", k, (mem_addr == 32'h2000) ? "D" : "I");
          mem_ack = 1'b1; mem_rdata = 32'h0;
          k++;
        end
      end
      check("grant_count", k, 10);
      i_req = 1'b0; d_req = 1'b0;
      for (int c = 0; c < 4; c++) begin
        step();
        mem_ack = mem_req;
      end
      mem_ack = 1'b0;
    end

    // Reset during GRANT_D abandons the transaction silently.
    d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h500; d_wdata = 32'hFEED_BEEF;
    step();
    check("pre_reset_mem_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    step();
    exp_err = 1'b0;
    check_all_zero("mid_reset");
    d_req = 1'b0; rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("no_ack_after_reset", {30'd0, i_ack, d_ack}, 32'd0);
    end
    ft = '{1'b0, 1'b0, 32'h600, 32'h0, 32'hC0DE_CAFE, 1, 32'hC0DE_CAFE, 1};
    run_txn(ft);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
